// File: rtl/shift_add_scaler.sv
// -----------------------------------------------------------------------------
// shift_add_scaler
//
// Sequential shift-add constant scaler. For an accepted unsigned sample x it
// computes y = sum over s with K_MASK[s]=1 of (x >> s), one shift position per
// clock. Each term is truncated on its own before it is added. A per-sample
// bypass flag passes x through unchanged.
//
// Parameters
//   W       data width (W >= 4)
//   K_MASK  W-bit shift mask; bit s set adds (x >> s)
//   SAT     0: sum bit W is presented on out_hi
//           1: results with sum bit W set saturate to all-ones and raise out_ovf
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   input sample valid
//   in_ready   block can accept a sample (high only when idle)
//   in_bypass  1: pass in_data through unscaled
//   in_data    unsigned input x (W bits)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_hi     bypass ? 1 : (SAT ? 0 : sum bit W)
//   out_data   result low W bits, or the saturated value
//   out_ovf    SAT=1 only: sum bit W was set
//   busy       block is not idle
//
// Timing: the accept cycle is followed by W RUN cycles (s = 0..W-1) and the
// result is presented in the next cycle, so out_valid rises W+1 cycles after
// accept. Bypass samples skip RUN and present one cycle after accept.
// -----------------------------------------------------------------------------
module shift_add_scaler #(
    parameter int           W      = 30,
    parameter logic [W-1:0] K_MASK = 30'h3E543D21,
    parameter bit           SAT    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_hi,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         busy
);

    localparam int              SW     = $clog2(W);
    localparam logic [SW-1:0]   S_LAST = SW'(W - 1);
    localparam logic [SW-1:0]   S_ONE  = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   x_r;
    logic [W:0]     acc_r;
    logic [SW-1:0]  s_r;
    logic           out_valid_r;
    logic           out_hi_r;
    logic [W-1:0]   out_data_r;
    logic           out_ovf_r;

    logic           accept_s;
    logic           run_last_s;
    logic [W:0]     term_s;
    logic [W:0]     acc_sum_s;
    logic [W+1:0]   result_s;

    // Formats a final sum as {ovf, hi, data} according to the overflow mode.
    function automatic logic [W+1:0] fmt_result(input logic [W:0] acc);
        logic [W+1:0] r;
        if (SAT) begin
            if (acc[W]) begin
                r = {1'b1, 1'b0, {W{1'b1}}};
            end else begin
                r = {1'b0, 1'b0, acc[W-1:0]};
            end
        end else begin
            r = {1'b0, acc[W], acc[W-1:0]};
        end
        return r;
    endfunction

    // Current shift term and running sum; the sum is W+1 bits and cannot wrap
    // because the terms add up to less than 2x.
    always_comb begin
        term_s = {(W + 1){1'b0}};
        if (K_MASK[s_r]) begin
            term_s = {1'b0, (x_r >> s_r)};
        end else begin
            term_s = {(W + 1){1'b0}};
        end
        acc_sum_s = acc_r + term_s;
        result_s  = fmt_result(acc_sum_s);
    end

    // Next-state logic and handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        run_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = in_bypass ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (s_r == S_LAST) begin
                    run_last_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample capture, accumulation and result registers. Result registers only
    // load on accept (bypass) or on the last RUN step, so they stay frozen while
    // DONE waits for out_ready and keep the last value once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= {W{1'b0}};
            acc_r       <= {(W + 1){1'b0}};
            s_r         <= {SW{1'b0}};
            out_valid_r <= 1'b0;
            out_hi_r    <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else if (accept_s) begin
            x_r   <= in_data;
            acc_r <= {(W + 1){1'b0}};
            s_r   <= {SW{1'b0}};
            if (in_bypass) begin
                out_valid_r <= 1'b1;
                out_hi_r    <= 1'b1;
                out_data_r  <= in_data;
                out_ovf_r   <= 1'b0;
            end
        end else if (state_r == ST_RUN) begin
            acc_r <= acc_sum_s;
            s_r   <= s_r + S_ONE;
            if (run_last_s) begin
                out_valid_r <= 1'b1;
                out_ovf_r   <= result_s[W+1];
                out_hi_r    <= result_s[W];
                out_data_r  <= result_s[W-1:0];
            end
        end else if ((state_r == ST_DONE) && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_hi    = out_hi_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_shift_add_scaler.sv
// -----------------------------------------------------------------------------
// tb_shift_add_scaler
//
// Two instances share one input stream: u_dut0 with SAT=0 and u_dut1 with
// SAT=1. Their timing is independent of the overflow mode, so both present
// each result in the same cycle. Directed vectors carry hand-computed results;
// the random phase uses a sum-of-shifted-terms reference model.
// -----------------------------------------------------------------------------
module tb_shift_add_scaler;

    localparam int          W    = 30;
    localparam logic [29:0] MASK = 30'h3E543D21;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_bypass;
    logic [29:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_hi0, out_ovf0, busy0;
    logic [29:0] out_data0;
    logic        in_ready1, out_valid1, out_hi1, out_ovf1, busy1;
    logic [29:0] out_data1;

    int n_checks;
    int n_errors;

    shift_add_scaler #(.W(W), .K_MASK(MASK), .SAT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_bypass(in_bypass), .in_data(in_data), .out_valid(out_valid0),
        .out_ready(out_ready), .out_hi(out_hi0), .out_data(out_data0),
        .out_ovf(out_ovf0), .busy(busy0)
    );

    shift_add_scaler #(.W(W), .K_MASK(MASK), .SAT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_bypass(in_bypass), .in_data(in_data), .out_valid(out_valid1),
        .out_ready(out_ready), .out_hi(out_hi1), .out_data(out_data1),
        .out_ovf(out_ovf1), .busy(busy1)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: sum of individually truncated shifted terms, W+1 bits.
    function automatic logic [30:0] ref_sum(input logic [29:0] x);
        logic [30:0] acc;
        acc = 31'd0;
        for (int s = 0; s < W; s++) begin
            if (MASK[s]) begin
                acc = acc + {1'b0, (x >> s)};
            end
        end
        return acc;
    endfunction

    // Checks presented results of both instances.
    task automatic check_out(input logic byp, input logic [29:0] e0d, input logic e0h,
                             input logic [29:0] e1d, input logic e1o);
        check("valid0", {31'd0, out_valid0}, 32'd1);
        check("valid1", {31'd0, out_valid1}, 32'd1);
        check("data0",  {2'b00, out_data0}, {2'b00, e0d});
        check("hi0",    {31'd0, out_hi0}, {31'd0, e0h});
        check("ovf0",   {31'd0, out_ovf0}, 32'd0);
        check("data1",  {2'b00, out_data1}, {2'b00, e1d});
        check("hi1",    {31'd0, out_hi1}, {31'd0, byp});
        check("ovf1",   {31'd0, out_ovf1}, {31'd0, e1o});
        check("rdy_done", {31'd0, in_ready0}, 32'd0);
        check("busy_done", {31'd0, busy0}, 32'd1);
    endtask

    // One full transaction: accept, latency, backpressure, release.
    task automatic run_sample(input logic [29:0] x, input logic byp, input int bp,
                              input logic pulse, input logic [29:0] e0d, input logic e0h,
                              input logic [29:0] e1d, input logic e1o);
        int lat;
        @(negedge clk);
        check("idle_rdy0", {31'd0, in_ready0}, 32'd1);
        check("idle_rdy1", {31'd0, in_ready1}, 32'd1);
        in_data   = x;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = ~x;
        in_bypass = ~byp;
        lat = 1;
        while (!out_valid0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, byp ? 32'd1 : 32'd31);
        check_out(byp, e0d, e0h, e1d, e1o);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            in_valid = pulse;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_out(byp, e0d, e0h, e1d, e1o);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rel_valid0", {31'd0, out_valid0}, 32'd0);
        check("rel_valid1", {31'd0, out_valid1}, 32'd0);
        check("rel_rdy", {31'd0, in_ready0}, 32'd1);
        check("rel_busy", {31'd0, busy0}, 32'd0);
        check("rel_keep", {2'b00, out_data0}, {2'b00, e0d});
    endtask

    // Reset-state checks on both instances.
    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {30'd0, out_valid1, out_valid0}, 32'd0);
        check({tag, "_rdy"},   {30'd0, in_ready1, in_ready0}, 32'd3);
        check({tag, "_busy"},  {30'd0, busy1, busy0}, 32'd0);
        check({tag, "_hi"},    {30'd0, out_hi1, out_hi0}, 32'd0);
        check({tag, "_ovf"},   {30'd0, out_ovf1, out_ovf0}, 32'd0);
    endtask

    // Main stimulus.
    initial begin
        logic [29:0] x;
        logic [30:0] sum;
        logic        byp;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        in_data   = 30'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        check("reset_data0", {2'b00, out_data0}, 32'd0);
        check("reset_data1", {2'b00, out_data1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        run_sample(30'h20000000, 1'b0, 0, 1'b0, 30'h212F0A9F, 1'b0, 30'h212F0A9F, 1'b0);
        run_sample(30'h3FFFFFFF, 1'b0, 2, 1'b0, 30'h025E152F, 1'b1, 30'h3FFFFFFF, 1'b1);
        run_sample(30'h12345678, 1'b1, 0, 1'b0, 30'h12345678, 1'b1, 30'h12345678, 1'b0);
        run_sample(30'h20000000, 1'b0, 10, 1'b1, 30'h212F0A9F, 1'b0, 30'h212F0A9F, 1'b0);
        run_sample(30'h00000001, 1'b0, 1, 1'b0, 30'h00000001, 1'b0, 30'h00000001, 1'b0);
        run_sample(30'h3FFFFFFF, 1'b1, 3, 1'b1, 30'h3FFFFFFF, 1'b1, 30'h3FFFFFFF, 1'b0);

        // Reset while RUN is at s=7.
        @(negedge clk);
        in_data   = 30'h3FFFFFFF;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrun_busy", {30'd0, busy1, busy0}, 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("midrun");
        run_sample(30'h00000000, 1'b0, 0, 1'b0, 30'h00000000, 1'b0, 30'h00000000, 1'b0);

        // Random samples against the reference model.
        for (int n = 0; n < 1000; n++) begin
            x   = 30'($urandom);
            if (n % 10 == 0) x = x | 30'h20000000;
            byp = ($urandom_range(0, 3) == 0);
            sum = ref_sum(x);
            if (byp) begin
                run_sample(x, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           x, 1'b1, x, 1'b0);
            end else begin
                run_sample(x, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           sum[29:0], sum[30], sum[30] ? 30'h3FFFFFFF : sum[29:0], sum[30]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
